gmii_to_rgmii_tx: RTL

- Transmit-side GMII-to-RGMII converter. Sits between the MAC TX GMII interface and an external DDR output primitive driving the RGMII TXD/TX_CTL pads.
- Produces per-edge 5-bit words: rising-edge and falling-edge {ctl, nibble}.
- In 1000 Mb/s mode it splits each byte across the two edges.
- In 10/100 mode it serialises each ClkEN-qualified byte into two nibble cycles with an FSM, and flags protocol violations.

---
 rtl/gmii_to_rgmii_tx.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/gmii_to_rgmii_tx.sv
// -----------------------------------------------------------------------------
// gmii_to_rgmii_tx
//
// Transmit-side GMII-to-RGMII converter. Produces the two per-edge 5-bit words
// {TX_CTL, TXD[3:0]} consumed by an external DDR output primitive.
//
//   1000 Mb/s (latched mode = 1): every byte is split across the two edges,
//   low nibble on the rising edge, high nibble on the falling edge. The
//   falling-edge ctl carries EN^ER, so carrier extension passes through.
//
//   10/100 (latched mode = 0): each ClkEN-qualified byte is serialised by an
//   FSM into a low-nibble cycle followed by a high-nibble cycle, with the same
//   nibble on both edges. A byte strobed while the previous byte is still in
//   its low-nibble cycle is dropped and flagged.
//
// Ports
//   TxClk        RGMII TX clock, all logic on its rising edge
//   rst          asynchronous active-high reset
//   TxD/TxEN/TxER  GMII transmit byte, enable, error
//   ClkEN        10/100 byte-valid strobe (ignored in 1000 mode)
//   GigMode      1 = 1000 Mb/s, 0 = 10/100; sampled only between frames
//   DdrDataH/L   {ctl, nibble} for the rising / falling edge
//   TxBusy       frame in progress
//   ByteDropErr  sticky 10/100 byte-loss flag, cleared only by rst
//   FrameCount   wrapping count of completed frames (TxBusy falling edges)
//
// Latency: input presented in cycle N appears on DdrDataH/L in cycle N+2
// (stage 1 capture register, stage 2 output register).
// -----------------------------------------------------------------------------
module gmii_to_rgmii_tx #(
   parameter int unsigned CNT_W     = 16,
   parameter logic [3:0]  IDLE_DATA = 4'h0
) (
   input  logic             TxClk,
   input  logic             rst,
   input  logic [7:0]       TxD,
   input  logic             TxEN,
   input  logic             TxER,
   input  logic             ClkEN,
   input  logic             GigMode,
   output logic [4:0]       DdrDataH,
   output logic [4:0]       DdrDataL,
   output logic             TxBusy,
   output logic             ByteDropErr,
   output logic [CNT_W-1:0] FrameCount
);

   typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

   // Stage 1 capture
   logic [7:0] d1_q;
   logic       en1_q, er1_q, ce1_q;

   // Mode latch and 10/100 serialiser state
   logic       mode_q, mode_d;
   state_e     state_q, state_d;
   logic [7:0] byte_q, byte_d;
   logic       berr_q, berr_d;

   // Stage 2 outputs and status
   logic [4:0]       ddr_h_q, ddr_h_d;
   logic [4:0]       ddr_l_q, ddr_l_d;
   logic             drop_q, drop_d;
   logic             busy_q;
   logic             tx_busy;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;

   // Busy follows the stage-1 enable in 1000 mode, the FSM in 10/100 mode.
   assign tx_busy = mode_q ? en1_q : (state_q != StIdle);
   assign accept  = ce1_q & en1_q;

   // Mode changes only between frames so a frame never mixes formats.
   always_comb begin
      mode_d = mode_q;
      if (!tx_busy) begin
         mode_d = GigMode;
      end
   end

   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      berr_d  = berr_q;
      drop_d  = drop_q;
      ddr_h_d = {1'b0, IDLE_DATA};
      ddr_l_d = {1'b0, IDLE_DATA};

      if (mode_q) begin
         // The serialiser is parked so the next 10/100 frame starts clean.
         state_d = StIdle;
         ddr_h_d = {en1_q, d1_q[3:0]};
         ddr_l_d = {en1_q ^ er1_q, d1_q[7:4]};
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  state_d = StLo;
                  byte_d  = d1_q;
                  berr_d  = er1_q;
               end
            end
            StLo: begin
               // Strobe before the low nibble has gone out: byte is lost.
               state_d = StHi;
               if (ce1_q) begin
                  drop_d = 1'b1;
               end
            end
            StHi: begin
               if (accept) begin
                  state_d = StLo;
                  byte_d  = d1_q;
                  berr_d  = er1_q;
               end else begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase

         // Outputs are registered alongside the state being entered.
         case (state_d)
            StLo: begin
               ddr_h_d = {1'b1, byte_d[3:0]};
               ddr_l_d = {~berr_d, byte_d[3:0]};
            end
            StHi: begin
               ddr_h_d = {1'b1, byte_d[7:4]};
               ddr_l_d = {~berr_d, byte_d[7:4]};
            end
            default: begin
               ddr_h_d = {1'b0, IDLE_DATA};
               ddr_l_d = {1'b0, IDLE_DATA};
            end
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (busy_q && !tx_busy) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge TxClk or posedge rst) begin
      if (rst) begin
         d1_q    <= '0;
         en1_q   <= 1'b0;
         er1_q   <= 1'b0;
         ce1_q   <= 1'b0;
         mode_q  <= 1'b0;
         state_q <= StIdle;
         byte_q  <= '0;
         berr_q  <= 1'b0;
         ddr_h_q <= '0;
         ddr_l_q <= '0;
         drop_q  <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         d1_q    <= TxD;
         en1_q   <= TxEN;
         er1_q   <= TxER;
         ce1_q   <= ClkEN;
         mode_q  <= mode_d;
         state_q <= state_d;
         byte_q  <= byte_d;
         berr_q  <= berr_d;
         ddr_h_q <= ddr_h_d;
         ddr_l_q <= ddr_l_d;
         drop_q  <= drop_d;
         busy_q  <= tx_busy;
         cnt_q   <= cnt_d;
      end
   end

   assign DdrDataH    = ddr_h_q;
   assign DdrDataL    = ddr_l_q;
   assign TxBusy      = tx_busy;
   assign ByteDropErr = drop_q;
   assign FrameCount  = cnt_q;

endmodule
